// File: rtl/factorial_seq.sv
// -----------------------------------------------------------------------------
// factorial_seq
//   Multi-cycle factorial engine. Accepts one operand through a valid/ready
//   handshake and computes number! using one multiply per clock. The result
//   is presented through a second valid/ready handshake. Only one request is
//   in flight at a time. A sticky flag reports results that do not fit in
//   OUT_W bits; the returned value is then number! modulo 2**OUT_W.
//
// Parameters
//   N      width of the operand (largest operand 2**N-1)
//   OUT_W  width of the factorial result
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      request valid
//   in_ready   out  1      engine can accept a request (high only in IDLE)
//   number     in   N      operand, sampled on accept
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts the result
//   factorial  out  OUT_W  number! truncated to OUT_W bits
//   overflow   out  1      true result exceeded 2**OUT_W-1
//   busy       out  1      engine is not in IDLE
// -----------------------------------------------------------------------------
module factorial_seq #(
  parameter int N     = 4,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] factorial,
  output logic             overflow,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [N-1:0]       i_q, i_d;
  logic [N-1:0]       n_q, n_d;
  logic               ovf_q, ovf_d;
  logic [OUT_W-1:0]   factorial_q, factorial_d;
  logic               overflow_q, overflow_d;
  logic               out_valid_q, out_valid_d;

  // Full-width product, so bits above OUT_W reveal overflow of this step.
  logic [OUT_W+N-1:0] prod;
  logic               prod_hi;

  always_comb begin
    prod        = {{N{1'b0}}, acc_q} * {{OUT_W{1'b0}}, i_q};
    prod_hi     = |prod[OUT_W+N-1:OUT_W];

    state_d     = state_q;
    acc_d       = acc_q;
    i_d         = i_q;
    n_d         = n_q;
    ovf_d       = ovf_q;
    factorial_d = factorial_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          n_d   = number;
          acc_d = {{(OUT_W-1){1'b0}}, 1'b1};
          i_d   = N'(2);
          ovf_d = 1'b0;
          if (number <= N'(1)) begin
            // 0! and 1! need no multiply: publish the result directly.
            state_d     = DONE;
            factorial_d = {{(OUT_W-1){1'b0}}, 1'b1};
            overflow_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        acc_d = prod[OUT_W-1:0];
        ovf_d = ovf_q | prod_hi;
        if (i_q == n_q) begin
          // Last multiply: register the result straight into the outputs.
          state_d     = DONE;
          factorial_d = prod[OUT_W-1:0];
          overflow_d  = ovf_q | prod_hi;
          out_valid_d = 1'b1;
        end else begin
          // i stops at n <= 2**N-1, so this increment cannot wrap.
          i_d = i_q + N'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= {{(OUT_W-1){1'b0}}, 1'b1};
      i_q         <= '0;
      n_q         <= '0;
      ovf_q       <= 1'b0;
      factorial_q <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      n_q         <= n_d;
      ovf_q       <= ovf_d;
      factorial_q <= factorial_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign factorial = factorial_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_factorial_seq.sv
// -----------------------------------------------------------------------------
// tb_factorial_seq
//   Directed bench for factorial_seq (N=4, OUT_W=32). Latency is counted as
//   rising edges after the accept edge until out_valid is seen: n<=1 shows
//   out_valid in the cycle right after accept (0 further edges), n>=2 needs
//   n-1 multiply edges.
// -----------------------------------------------------------------------------
module tb_factorial_seq;

  localparam int N     = 4;
  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     number;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] factorial;
  logic             overflow;
  logic             busy;

  int total = 0;
  int bad   = 0;

  factorial_seq #(.N(N), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .number    (number),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .factorial (factorial),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE, wait for the result, then consume it.
  task automatic do_req(input logic [N-1:0] n, output int lat,
                        output logic [OUT_W-1:0] f, output logic o,
                        output logic tmo);
    in_valid  = 1'b1;
    number    = n;
    out_ready = 1'b0;
    step();
    in_valid  = 1'b0;
    number    = ~n;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    tmo = !out_valid;
    f   = factorial;
    o   = overflow;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; number = '0; out_ready = 1'b0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (factorial !== 32'd0) begin bad++; $display("FAIL rst_factorial got=%0d want=0", factorial); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b want=0", overflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat;
    in_valid = 1'b1; number = 4'd5; out_ready = 1'b0;
    step();
    in_valid = 1'b0; number = 4'd2;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL calc_busy got=%b want=1", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL calc_in_ready got=%b want=0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 100) begin step(); lat++; end
    total++; if (lat !== 4) begin bad++; $display("FAIL lat_5 got=%0d want=4", lat); end
    total++; if (factorial !== 32'd120) begin bad++; $display("FAIL fact_5 got=%0d want=120", factorial); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_5 got=%b want=0", overflow); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drop_5 got=%b want=0", out_valid); end
    total++; if (factorial !== 32'd120) begin bad++; $display("FAIL hold_idle got=%0d want=120", factorial); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_small();
    int lat; logic [OUT_W-1:0] f; logic o; logic tmo;
    for (int k = 0; k < 2; k++) begin
      do_req(N'(k), lat, f, o, tmo);
      total++; if (tmo) begin bad++; $display("FAIL tmo_small n=%0d no out_valid", k); end
      total++; if (lat !== 0) begin bad++; $display("FAIL lat_small n=%0d got=%0d want=0", k, lat); end
      total++; if (f !== 32'd1) begin bad++; $display("FAIL fact_small n=%0d got=%0d want=1", k, f); end
      total++; if (o !== 1'b0) begin bad++; $display("FAIL ovf_small n=%0d got=%b want=0", k, o); end
    end
  endtask

  task automatic test_large();
    int lat; logic [OUT_W-1:0] f; logic o; logic tmo;
    do_req(4'd12, lat, f, o, tmo);
    total++; if (tmo) begin bad++; $display("FAIL tmo_12 no out_valid"); end
    total++; if (lat !== 11) begin bad++; $display("FAIL lat_12 got=%0d want=11", lat); end
    total++; if (f !== 32'd479001600) begin bad++; $display("FAIL fact_12 got=%0d want=479001600", f); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL ovf_12 got=%b want=0", o); end
    do_req(4'd15, lat, f, o, tmo);
    total++; if (tmo) begin bad++; $display("FAIL tmo_15 no out_valid"); end
    total++; if (lat !== 14) begin bad++; $display("FAIL lat_15 got=%0d want=14", lat); end
    total++; if (f !== 32'd2004310016) begin bad++; $display("FAIL fact_15 got=%0d want=2004310016", f); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL ovf_15 got=%b want=1", o); end
  endtask

  task automatic test_backpressure();
    int lat;
    in_valid = 1'b1; number = 4'd13; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin step(); lat++; end
    total++; if (lat !== 12) begin bad++; $display("FAIL lat_13 got=%0d want=12", lat); end
    // in_valid is raised while stalled; it must not be taken.
    in_valid = 1'b1; number = 4'd3;
    for (int c = 0; c < 10; c++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%b want=1", c, out_valid); end
      total++; if (factorial !== 32'd1932053504) begin bad++; $display("FAIL bp_fact c=%0d got=%0d want=1932053504", c, factorial); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf c=%0d got=%b want=1", c, overflow); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b want=0", c, in_ready); end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_release_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [OUT_W-1:0] f; logic o; logic tmo;
    in_valid = 1'b1; number = 4'd9; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    // Third CALC cycle: factorial/overflow still hold 13! with overflow set.
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
    total++; if (factorial !== 32'd0) begin bad++; $display("FAIL mid_rst_fact got=%0d want=0", factorial); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf got=%b want=0", overflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    step();
    rst_n = 1'b1;
    step();
    do_req(4'd3, lat, f, o, tmo);
    total++; if (tmo) begin bad++; $display("FAIL tmo_3 no out_valid"); end
    total++; if (lat !== 2) begin bad++; $display("FAIL lat_3 got=%0d want=2", lat); end
    total++; if (f !== 32'd6) begin bad++; $display("FAIL fact_3 got=%0d want=6", f); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL ovf_3 got=%b want=0", o); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]     vals [3];
    logic [OUT_W-1:0] exp_f [3];
    logic [OUT_W-1:0] got [$];
    int idx;
    int cyc;
    vals[0] = 4'd4;  vals[1] = 4'd6;  vals[2] = 4'd2;
    exp_f[0] = 32'd24; exp_f[1] = 32'd720; exp_f[2] = 32'd2;
    idx = 0; cyc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    number    = vals[0];
    while (got.size() < 3 && cyc < 200) begin
      logic take;
      if (out_valid) got.push_back(factorial);
      take = in_valid && in_ready;
      step();
      cyc++;
      if (take) begin
        idx++;
        if (idx < 3) number = vals[idx];
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    total++; if (got.size() !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) begin
        total++; if (got[k] !== exp_f[k]) begin bad++; $display("FAIL b2b_res k=%0d got=%0d want=%0d", k, got[k], exp_f[k]); end
      end
    end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_extra got=%b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small();
    test_large();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
